// File: rtl/retire.sv
// Retire/writeback stage: registers the retiring uop (RB0 -> RB1), drives the RF write port,
// counts retired uops, tracks last PC and runs a RUN/DRAIN/HALTED quiesce FSM.
// Optional RB0 forwarding port enabled by defining RETIRE_BYPASS_EN.
// uinstr_mm1 packing: [37] valid, [36:32] rd, [31:0] pc.
module retire #(
    parameter int CNT_W        = 64,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [37:0]      uinstr_mm1,
    input  logic [31:0]      result_mm1,
    input  logic             halt_req,
    input  logic             resume,
    output logic             rf_wr_en,
    output logic [4:0]       rf_wr_addr,
    output logic [31:0]      rf_wr_data,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [31:0]      last_pc,
    output logic             halted,
    output logic             retire_err,
    output logic             byp_valid,
    output logic [4:0]       byp_rd,
    output logic [31:0]      byp_data
);

    localparam int IDLE_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    logic        mm1_valid;
    logic [4:0]  mm1_rd;
    logic [31:0] mm1_pc;

    assign mm1_valid = uinstr_mm1[37];
    assign mm1_rd    = uinstr_mm1[36:32];
    assign mm1_pc    = uinstr_mm1[31:0];

    logic              rb1_valid_q, rb1_valid_d;
    logic [4:0]        rb1_rd_q, rb1_rd_d;
    logic [31:0]       rb1_data_q, rb1_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       last_pc_q, last_pc_d;
    logic              err_q, err_d;
    state_t            state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    // Retire datapath: counter and last PC move on the same edge that loads RB1,
    // so they agree with the rf_wr_* port in the cycle the uop is visible there.
    always_comb begin
        rb1_valid_d = mm1_valid;
        rb1_rd_d    = mm1_rd;
        rb1_data_d  = result_mm1;
        cnt_d       = cnt_q;
        last_pc_d   = last_pc_q;
        err_d       = err_q;
        if (mm1_valid) begin
            cnt_d     = cnt_q + CNT_W'(1);
            last_pc_d = mm1_pc;
        end
        if (rb1_valid_q && (state_q == ST_HALTED)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    idle_d  = '0;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else begin
                    if (mm1_valid) begin
                        idle_d = '0;
                    end else if (idle_q != IDLE_MAX) begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                    // Halt on the edge that completes the last required idle cycle.
                    if (idle_d == IDLE_MAX) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                idle_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb1_valid_q <= 1'b0;
            rb1_rd_q    <= '0;
            rb1_data_q  <= '0;
            cnt_q       <= '0;
            last_pc_q   <= '0;
            err_q       <= 1'b0;
            state_q     <= ST_RUN;
            idle_q      <= '0;
        end else begin
            rb1_valid_q <= rb1_valid_d;
            rb1_rd_q    <= rb1_rd_d;
            rb1_data_q  <= rb1_data_d;
            cnt_q       <= cnt_d;
            last_pc_q   <= last_pc_d;
            err_q       <= err_d;
            state_q     <= state_d;
            idle_q      <= idle_d;
        end
    end

    assign rf_wr_en   = rb1_valid_q && (rb1_rd_q != 5'd0);
    assign rf_wr_addr = rb1_rd_q;
    assign rf_wr_data = rb1_data_q;
    assign retire_cnt = cnt_q;
    assign last_pc    = last_pc_q;
    assign halted     = (state_q == ST_HALTED);
    assign retire_err = err_q;

`ifdef RETIRE_BYPASS_EN
    assign byp_valid = mm1_valid && (mm1_rd != 5'd0);
    assign byp_rd    = mm1_rd;
    assign byp_data  = result_mm1;
`else
    assign byp_valid = 1'b0;
    assign byp_rd    = 5'd0;
    assign byp_data  = 32'd0;
`endif

endmodule

// File: tb/tb_retire.sv
// Directed self-checking bench for retire: writeback timing, x0 suppression, back-to-back
// retirement, halt/drain/resume FSM, sticky retire_err, bypass port and async reset.
module tb_retire;

`ifdef RETIRE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] uinstr_mm1;
    logic [31:0] result_mm1;
    logic        halt_req;
    logic        resume;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [63:0] retire_cnt;
    logic [31:0] last_pc;
    logic        halted;
    logic        retire_err;
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    retire #(.CNT_W(64), .DRAIN_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .uinstr_mm1 (uinstr_mm1),
        .result_mm1 (result_mm1),
        .halt_req   (halt_req),
        .resume     (resume),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .retire_cnt (retire_cnt),
        .last_pc    (last_pc),
        .halted     (halted),
        .retire_err (retire_err),
        .byp_valid  (byp_valid),
        .byp_rd     (byp_rd),
        .byp_data   (byp_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] data);
        uinstr_mm1 = {v, rd, pc};
        result_mm1 = data;
    endtask

    initial begin
        logic [63:0] exp_cnt;
        reset    = 1'b1;
        halt_req = 1'b0;
        resume   = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        tick();
        check("rst_wr_en",  {63'd0, rf_wr_en}, 64'd0);
        check("rst_addr",   {59'd0, rf_wr_addr}, 64'd0);
        check("rst_data",   {32'd0, rf_wr_data}, 64'd0);
        check("rst_cnt",    retire_cnt, 64'd0);
        check("rst_pc",     {32'd0, last_pc}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_err",    {63'd0, retire_err}, 64'd0);
        reset = 1'b0;
        exp_cnt = 64'd0;

        // Single uop rd=5; bypass is combinational in the same cycle.
        drive(1'b1, 5'd5, 32'h100, 32'hDEADBEEF);
        #1;
        check("byp_valid_rd5", {63'd0, byp_valid}, {63'd0, BYP});
        check("byp_rd_rd5",    {59'd0, byp_rd}, BYP ? 64'd5 : 64'd0);
        check("byp_data_rd5",  {32'd0, byp_data}, BYP ? 64'hDEADBEEF : 64'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        exp_cnt = 64'd1;
        check("wr_en_rd5",  {63'd0, rf_wr_en}, 64'd1);
        check("addr_rd5",   {59'd0, rf_wr_addr}, 64'd5);
        check("data_rd5",   {32'd0, rf_wr_data}, 64'hDEADBEEF);
        check("cnt_rd5",    retire_cnt, exp_cnt);
        check("pc_rd5",     {32'd0, last_pc}, 64'h100);
        tick();
        check("wr_en_idle", {63'd0, rf_wr_en}, 64'd0);
        check("pc_hold",    {32'd0, last_pc}, 64'h100);

        // rd=x0: counted but not written, and not forwarded.
        drive(1'b1, 5'd0, 32'h104, 32'hCAFE);
        #1;
        check("byp_valid_x0", {63'd0, byp_valid}, 64'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        exp_cnt = 64'd2;
        check("wr_en_x0", {63'd0, rf_wr_en}, 64'd0);
        check("cnt_x0",   retire_cnt, exp_cnt);
        check("pc_x0",    {32'd0, last_pc}, 64'h104);

        // Ten back-to-back uops, one write per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(i + 1), 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
            tick();
            check("b2b_wr_en", {63'd0, rf_wr_en}, 64'd1);
            check("b2b_addr",  {59'd0, rf_wr_addr}, 64'(i + 1));
            check("b2b_data",  {32'd0, rf_wr_data}, 64'h1000 + 64'(i));
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        exp_cnt = 64'd12;
        check("b2b_cnt", retire_cnt, exp_cnt);
        check("b2b_pc",  {32'd0, last_pc}, 64'h224);

        // rd=7 bypass vector.
        drive(1'b1, 5'd7, 32'h240, 32'h1234);
        #1;
        check("byp_valid_rd7", {63'd0, byp_valid}, {63'd0, BYP});
        check("byp_rd_rd7",    {59'd0, byp_rd}, BYP ? 64'd7 : 64'd0);
        check("byp_data_rd7",  {32'd0, byp_data}, BYP ? 64'h1234 : 64'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        exp_cnt = 64'd13;
        check("cnt_rd7", retire_cnt, exp_cnt);

        // Halt with uops on cycles 0 and 2: halted after 4 idle cycles (post cycle 6).
        halt_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 0 || k == 2) drive(1'b1, 5'd1, 32'h300 + 32'(k), 32'h0);
            else                  drive(1'b0, 5'd0, 32'd0, 32'd0);
            tick();
            check($sformatf("drain1_halted_c%0d", k), {63'd0, halted}, (k == 6) ? 64'd1 : 64'd0);
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        exp_cnt = 64'd15;
        check("drain1_cnt", retire_cnt, exp_cnt);
        check("drain1_err", {63'd0, retire_err}, 64'd0);

        // Uop retired while halted sets the sticky error.
        drive(1'b1, 5'd9, 32'h400, 32'h55);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        check("halted_wr_en", {63'd0, rf_wr_en}, 64'd1);
        tick();
        check("halted_err",  {63'd0, retire_err}, 64'd1);
        check("halted_hold", {63'd0, halted}, 64'd1);
        resume   = 1'b1;
        halt_req = 1'b0;
        tick();
        resume = 1'b0;
        check("resume_halted", {63'd0, halted}, 64'd0);
        check("resume_err",    {63'd0, retire_err}, 64'd1);
        tick();
        check("run_err_sticky", {63'd0, retire_err}, 64'd1);

        // Resume and halt_req together: back to RUN, then DRAIN, then halt again.
        halt_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("drain2_halted_c%0d", k), {63'd0, halted}, (k == 4) ? 64'd1 : 64'd0);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("both_resume_wins", {63'd0, halted}, 64'd0);
        for (int j = 0; j < 5; j++) begin
            tick();
            check($sformatf("redrain_halted_c%0d", j), {63'd0, halted}, (j == 4) ? 64'd1 : 64'd0);
        end
        resume   = 1'b1;
        halt_req = 1'b0;
        tick();
        resume = 1'b0;
        check("resume2_halted", {63'd0, halted}, 64'd0);

        // Dropping halt_req mid-drain returns to RUN; the idle count restarts on re-entry.
        halt_req = 1'b1;
        repeat (3) tick();
        halt_req = 1'b0;
        tick();
        check("drop_halted", {63'd0, halted}, 64'd0);
        halt_req = 1'b1;
        repeat (4) tick();
        check("drop_redrain_3idle", {63'd0, halted}, 64'd0);
        tick();
        check("drop_redrain_4idle", {63'd0, halted}, 64'd1);
        resume   = 1'b1;
        halt_req = 1'b0;
        tick();
        resume = 1'b0;

        // Resume pulse outside HALTED has no effect.
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_in_run", {63'd0, halted}, 64'd0);

        // Async reset while RB1 holds an rd=3 uop, mid-drain.
        halt_req = 1'b1;
        tick();
        drive(1'b1, 5'd3, 32'h500, 32'hA5A5);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        check("pre_rst_wr_en", {63'd0, rf_wr_en}, 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_wr_en",  {63'd0, rf_wr_en}, 64'd0);
        check("midrst_cnt",    retire_cnt, 64'd0);
        check("midrst_pc",     {32'd0, last_pc}, 64'd0);
        check("midrst_err",    {63'd0, retire_err}, 64'd0);
        check("midrst_halted", {63'd0, halted}, 64'd0);
        halt_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) tick();
        check("postrst_wr_en",  {63'd0, rf_wr_en}, 64'd0);
        check("postrst_halted", {63'd0, halted}, 64'd0);
        check("postrst_cnt",    retire_cnt, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
